// File: rtl/fastpow_mod.sv
// fastpow_mod: sequential square-and-multiply exponentiation, out = x^n.
// Two modes:
//   mod_en=0 : result truncated to W bits; ovf reports lost high bits.
//   mod_en=1 : result reduced modulo inm. A restoring reducer runs after each
//              multiply step and produces one quotient bit per cycle.
// Ports:
//   clk, nrst           clock and asynchronous active-low reset
//   start / ready       request, sampled only while ready=1
//   inx, inn, inm       base, exponent, modulus (latched on the accepting edge)
//   mod_en              mode select (latched on the accepting edge)
//   out, ovf, err       registered results, held until the next completion
//   done                one-cycle pulse when out is updated
module fastpow_mod #(
  parameter int W  = 16,
  parameter int NW = 8
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          start,
  input  logic [W-1:0]  inx,
  input  logic [NW-1:0] inn,
  input  logic [W-1:0]  inm,
  input  logic          mod_en,
  output logic [W-1:0]  out,
  output logic          ready,
  output logic          done,
  output logic          ovf,
  output logic          err
);

  localparam int CW = $clog2(2*W);

  typedef enum logic [1:0] {IDLE, STEP, RED, FIN} state_t;

  state_t          state_q;
  logic [W-1:0]    x_q, a_q, m_q;
  logic [NW-1:0]   n_q;
  logic            mode_q, xovf_q, aovf_q, errp_q, bit_q;
  logic [2*W-1:0]  da_q, dx_q;     // dividends being shifted out, MSB first
  logic [W:0]      ra_q, rx_q;     // partial remainders
  logic [CW-1:0]   cnt_q;

  logic [W-1:0]    out_q;
  logic            ready_q, done_q, ovf_q, err_q;

  // Full-width products
  logic [2*W-1:0]  pa, px;
  assign pa = {{W{1'b0}}, a_q} * {{W{1'b0}}, x_q};
  assign px = {{W{1'b0}}, x_q} * {{W{1'b0}}, x_q};

  // One restoring-division step for each dividend
  logic [W:0] m_ext, ra_sh, rx_sh, ra_nx, rx_nx;
  assign m_ext = {1'b0, m_q};
  assign ra_sh = {ra_q[W-1:0], da_q[2*W-1]};
  assign rx_sh = {rx_q[W-1:0], dx_q[2*W-1]};
  assign ra_nx = (ra_sh >= m_ext) ? ra_sh - m_ext : ra_sh;
  assign rx_nx = (rx_sh >= m_ext) ? rx_sh - m_ext : rx_sh;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      x_q     <= '0;
      a_q     <= '0;
      m_q     <= '0;
      n_q     <= '0;
      mode_q  <= 1'b0;
      xovf_q  <= 1'b0;
      aovf_q  <= 1'b0;
      errp_q  <= 1'b0;
      bit_q   <= 1'b0;
      da_q    <= '0;
      dx_q    <= '0;
      ra_q    <= '0;
      rx_q    <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: if (start) begin
          x_q     <= inx;
          m_q     <= inm;
          mode_q  <= mod_en;
          // modulus 1: every residue is 0, including x^0
          a_q     <= (mod_en && inm == W'(1)) ? '0 : W'(1);
          // modulus 0: force n=0 so STEP falls straight through to FIN,
          // which keeps the error path at the same 2-cycle latency as n=0
          n_q     <= (mod_en && inm == '0) ? '0 : inn;
          errp_q  <= mod_en && (inm == '0);
          xovf_q  <= 1'b0;
          aovf_q  <= 1'b0;
          ready_q <= 1'b0;
          state_q <= STEP;
        end
        STEP: begin
          if (n_q == '0) begin
            state_q <= FIN;
          end else begin
            n_q   <= n_q >> 1;
            bit_q <= n_q[0];
            if (mode_q) begin
              da_q    <= pa;
              dx_q    <= px;
              ra_q    <= '0;
              rx_q    <= '0;
              cnt_q   <= CW'(2*W-1);
              state_q <= RED;
            end else begin
              if (n_q[0]) a_q <= pa[W-1:0];
              x_q <= px[W-1:0];
              // a truncated x only pollutes a when it is actually multiplied
              // in, so the trailing discarded square never reaches aovf
              aovf_q <= aovf_q | (n_q[0] & (xovf_q | (pa[2*W-1:W] != '0)));
              xovf_q <= xovf_q | (px[2*W-1:W] != '0);
            end
          end
        end
        RED: begin
          da_q  <= da_q << 1;
          dx_q  <= dx_q << 1;
          ra_q  <= ra_nx;
          rx_q  <= rx_nx;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            x_q <= rx_nx[W-1:0];
            if (bit_q) a_q <= ra_nx[W-1:0];
            state_q <= STEP;
          end
        end
        FIN: begin
          out_q   <= errp_q ? '0 : a_q;
          ovf_q   <= mode_q ? 1'b0 : aovf_q;
          err_q   <= errp_q;
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out   = out_q;
  assign ready = ready_q;
  assign done  = done_q;
  assign ovf   = ovf_q;
  assign err   = err_q;

endmodule

// File: tb/tb_fastpow_mod.sv
// Directed bench for fastpow_mod (W=16, NW=8) with hand-computed results.
module tb_fastpow_mod;

  logic        clk, nrst, start, mod_en;
  logic [15:0] inx, inm;
  logic [7:0]  inn;
  logic [15:0] out;
  logic        ready, done, ovf, err;

  int checks   = 0;
  int failures = 0;

  fastpow_mod #(.W(16), .NW(8)) dut (
    .clk(clk), .nrst(nrst), .start(start), .inx(inx), .inn(inn), .inm(inm),
    .mod_en(mod_en), .out(out), .ready(ready), .done(done), .ovf(ovf), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request and returns the number of edges from the accepting
  // edge until done is seen (capped at 5000 so a hang shows as a bad latency).
  task automatic run(input logic [15:0] x, input logic [7:0] n,
                     input logic [15:0] m, input logic md, output int cyc);
    inx = x; inn = n; inm = m; mod_en = md; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    nrst = 1'b0; start = 1'b0; inx = '0; inn = '0; inm = '0; mod_en = 1'b0;
    #12;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %0b exp 1", ready); end
    checks++; if (out !== 16'd0) begin failures++; $display("FAIL reset_out got %0d exp 0", out); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got %0b exp 0", done); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got %0b exp 0", ovf); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got %0b exp 0", err); end
    @(negedge clk); nrst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_trunc_basic;
    int c;
    run(16'd3, 8'd5, 16'd0, 1'b0, c);
    checks++; if (out !== 16'd243) begin failures++; $display("FAIL trunc_3p5_out got %0d exp 243", out); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL trunc_3p5_ovf got %0b exp 0", ovf); end
    checks++; if (c !== 5) begin failures++; $display("FAIL trunc_3p5_lat got %0d exp 5", c); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL trunc_3p5_ready got %0b exp 1", ready); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL trunc_3p5_done_width got %0b exp 0", done); end
  endtask

  task automatic test_reset_midrun;
    int seen;
    inx = 16'd3; inn = 8'd200; inm = '0; mod_en = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #2 nrst = 1'b0;
    #1;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got %0b exp 1", ready); end
    checks++; if (out !== 16'd0) begin failures++; $display("FAIL midrst_out got %0d exp 0", out); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL midrst_ovf got %0b exp 0", ovf); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL midrst_err got %0b exp 0", err); end
    seen = 0;
    repeat (3) begin @(posedge clk); #1; if (done) seen++; end
    @(negedge clk); nrst = 1'b1;
    repeat (20) begin @(posedge clk); #1; if (done) seen++; end
    checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_no_done got %0d pulses exp 0", seen); end
  endtask

  task automatic test_trunc_ovf;
    int c;
    run(16'd3, 8'd13, 16'd0, 1'b0, c);
    checks++; if (out !== 16'd21459) begin failures++; $display("FAIL ovf_3p13_out got %0d exp 21459", out); end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_3p13_ovf got %0b exp 1", ovf); end
    checks++; if (c !== 6) begin failures++; $display("FAIL ovf_3p13_lat got %0d exp 6", c); end
    run(16'd2, 8'd16, 16'd0, 1'b0, c);
    checks++; if (out !== 16'd0) begin failures++; $display("FAIL ovf_2p16_out got %0d exp 0", out); end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_2p16_ovf got %0b exp 1", ovf); end
    checks++; if (c !== 7) begin failures++; $display("FAIL ovf_2p16_lat got %0d exp 7", c); end
    run(16'd2, 8'd15, 16'd0, 1'b0, c);
    checks++; if (out !== 16'd32768) begin failures++; $display("FAIL ovf_2p15_out got %0d exp 32768", out); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_2p15_ovf got %0b exp 0", ovf); end
  endtask

  task automatic test_modular;
    int c;
    run(16'd7, 8'd10, 16'd13, 1'b1, c);
    checks++; if (out !== 16'd4) begin failures++; $display("FAIL mod_7p10_out got %0d exp 4", out); end
    checks++; if (c !== 134) begin failures++; $display("FAIL mod_7p10_lat got %0d exp 134", c); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL mod_7p10_ovf got %0b exp 0", ovf); end
    run(16'd20, 8'd3, 16'd13, 1'b1, c);
    checks++; if (out !== 16'd5) begin failures++; $display("FAIL mod_20p3_out got %0d exp 5", out); end
    checks++; if (c !== 68) begin failures++; $display("FAIL mod_20p3_lat got %0d exp 68", c); end
    // 60000^2 needs all 32 dividend bits; 60000 mod 1000 = 0
    run(16'd60000, 8'd2, 16'd1000, 1'b1, c);
    checks++; if (out !== 16'd0) begin failures++; $display("FAIL mod_big_out got %0d exp 0", out); end
    // 65535^3 mod 65521 = 14^3 = 2744
    run(16'd65535, 8'd3, 16'd65521, 1'b1, c);
    checks++; if (out !== 16'd2744) begin failures++; $display("FAIL mod_wide_out got %0d exp 2744", out); end
  endtask

  task automatic test_edges;
    int c;
    run(16'd9, 8'd0, 16'd0, 1'b0, c);
    checks++; if (out !== 16'd1) begin failures++; $display("FAIL n0_out got %0d exp 1", out); end
    checks++; if (c !== 2) begin failures++; $display("FAIL n0_lat got %0d exp 2", c); end
    run(16'd0, 8'd6, 16'd0, 1'b0, c);
    checks++; if (out !== 16'd0) begin failures++; $display("FAIL x0_out got %0d exp 0", out); end
    run(16'd9, 8'd0, 16'd5, 1'b1, c);
    checks++; if (out !== 16'd1) begin failures++; $display("FAIL mod_n0_out got %0d exp 1", out); end
    run(16'd5, 8'd3, 16'd1, 1'b1, c);
    checks++; if (out !== 16'd0) begin failures++; $display("FAIL m1_out got %0d exp 0", out); end
    run(16'd5, 8'd3, 16'd0, 1'b1, c);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL m0_err got %0b exp 1", err); end
    checks++; if (out !== 16'd0) begin failures++; $display("FAIL m0_out got %0d exp 0", out); end
    checks++; if (c !== 2) begin failures++; $display("FAIL m0_lat got %0d exp 2", c); end
    run(16'd3, 8'd4, 16'd0, 1'b0, c);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_clear got %0b exp 0", err); end
    checks++; if (out !== 16'd81) begin failures++; $display("FAIL err_clear_out got %0d exp 81", out); end
  endtask

  task automatic test_back_to_back;
    int c, c2, wide, pulses;
    logic prev;
    inx = 16'd3; inn = 8'd5; inm = '0; mod_en = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    c = 0; wide = 0; pulses = 0; prev = 1'b0;
    while (!done && c < 200) begin @(posedge clk); #1; c++; end
    checks++; if (c !== 5) begin failures++; $display("FAIL b2b_first_lat got %0d exp 5", c); end
    checks++; if (out !== 16'd243) begin failures++; $display("FAIL b2b_first_out got %0d exp 243", out); end
    pulses = 1; prev = 1'b1;
    // start still high: the edge after done must accept a new run
    @(posedge clk); #1;
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL b2b_reaccept_ready got %0b exp 0", ready); end
    if (done && prev) wide++;
    prev = done;
    c2 = 0;
    while (!done && c2 < 200) begin @(posedge clk); #1; c2++; end
    start = 1'b0;
    checks++; if (c2 !== 5) begin failures++; $display("FAIL b2b_second_lat got %0d exp 5", c2); end
    pulses++; prev = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (done && prev) wide++;
      if (done) pulses++;
      prev = done;
    end
    checks++; if (wide !== 0) begin failures++; $display("FAIL b2b_done_width got %0d wide exp 0", wide); end
    checks++; if (pulses !== 2) begin failures++; $display("FAIL b2b_pulses got %0d exp 2", pulses); end
  endtask

  initial begin
    test_reset;
    test_trunc_basic;
    test_reset_midrun;
    test_trunc_ovf;
    test_modular;
    test_edges;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fastpow_mod.md
Name: fastpow_mod

Overview:
- Sequential square-and-multiply exponentiation unit computing out = x^n, either truncated to W bits or reduced modulo a runtime modulus m.
- Parametrised successor of the team's fixed 16/8-bit fast-power circuit.
- Adds generic widths, a modular mode with a sequential restoring reducer, overflow/error flags and a one-cycle done pulse.
- Used by the Lista11 datapath exercises as a start/ready coprocessor.

Parameters:
- W, 16, operand/result width (x, m, out).
- NW, 8, exponent width (n).

Ports:
- clk  input  1  clock, all state changes on posedge.
- nrst  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only while ready=1.
- inx  input  W  base.
- inn  input  NW  exponent.
- inm  input  W  modulus; used only when mod_en=1.
- mod_en  input  1  1 = modular mode, 0 = truncate to W bits.
- out  output  W  result, registered; holds until next completion.
- ready  output  1  1 = idle, accepts start.
- done  output  1  one-cycle pulse when out is updated.
- ovf  output  1  truncating mode: result lost high bits; valid with done, held.
- err  output  1  modular mode with inm=0; valid with done, held.

Behaviour:
- Reset (async, any state): state=IDLE; ready=1, out=0, done=0, ovf=0, err=0. Reset mid-operation aborts with no completion pulse.
- IDLE: on start=1, latch x=inx, n=inn, m=inm, mode=mod_en. Set a=1 (a=0 if mode=1 and inm=1), xovf=0, aovf=0, ready=0, then go to STEP.
- If mode=1 and inm=0, go directly to FIN with err=1 and out=0.
- start while ready=0 is ignored. Inputs other than start are sampled only on the accepting edge.
- STEP, if n==0: go to FIN.
- STEP, otherwise compute full 2W-bit products pa=a*x (if n[0]=1) and px=x*x, then shift n right by 1.
  - mode=0: a<=pa[W-1:0] (if n[0]); x<=px[W-1:0].
  - mode=0: aovf|= n[0] & (xovf | pa[2W-1:W]!=0); xovf|= (px[2W-1:W]!=0). Stay in STEP.
  - mode=1: register pa and px into reducer registers, go to RED.
- RED: restoring reduction of both 2W-bit values modulo m in parallel.
  - One quotient bit per cycle, MSB first, exactly 2W cycles.
  - Remainder register is W+1 bits.
  - Then a<=pa mod m (only if that step had n[0]=1), x<=px mod m, and return to STEP.
- FIN (one cycle): out<=a (err case: 0), ovf<=aovf (mode=1: 0), err as set, done=1, ready=1, go to IDLE.
- done is high exactly one cycle; ready rises in the same cycle as done.
- Latency from the accepting edge to done/ready high, with k = bit length of inn (k=0 for inn=0):
  - mode=0: k+2 cycles.
  - mode=1: k*(2W+1)+2 cycles.
  - err case: 2 cycles.
- inn=0 gives out=1 (mode=1: 1 mod m).
- inx=0 with inn>0 gives 0.
- inx>=inm is legal; the reducer handles unreduced x.
- The final squaring after the last exponent bit is performed and discarded; it must not affect ovf.
- start asserted in the same cycle as done (ready=0 at that edge) is ignored; it is accepted on the next edge.

Test Plan:
- Reset mid-run: mode=0, inx=3, inn=200; assert nrst=0 on cycle 3 -> ready=1, out=0, ovf=0, err=0 immediately (async), no done pulse.
- Truncating basic: mode=0, inx=3, inn=5 -> out=243, ovf=0, done exactly 5 cycles after acceptance.
- Truncating overflow: mode=0, inx=3, inn=13 -> out=21459, ovf=1. Separately inx=2, inn=16 -> out=0, ovf=1. Separately inx=2, inn=15 -> out=32768, ovf=0 (the discarded final square overflows but ovf stays 0).
- Modular: mode=1, W=16, inx=7, inn=10, inm=13 -> out=4, done 4*33+2=134 cycles after acceptance. Also inx=20, inn=3, inm=13 -> out=5 (unreduced base).
- Edge exponents/moduli: inn=0, mode=0 -> out=1 after 2 cycles. mode=1, inm=1 -> out=0. mode=1, inm=0 -> err=1, out=0 after 2 cycles; next valid run clears err.
- Handshake: start held high continuously for a 3^5 run -> exactly one computation while busy; a new run is accepted on the edge after done; done never wider than 1 cycle.
